// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared types for the fetch/data memory arbiter: FSM state
//                encoding and owner encoding constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner encoding, also the value seen on the owner output
    localparam logic c_owner_fetch = 1'b0;
    localparam logic c_owner_data  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the fetch port, data port and shared memory port
//                of the memory arbiter. The slave modport is the arbiter's
//                view; the master modport is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    // Load/store port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    // Shared memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Two-way winner selection between fetch and data requests.
//                Default: fixed priority, data wins. With ARB_RR_EN defined:
//                on contention the requester that was not granted last wins.
//                With no request the last owner is passed through.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import riscv_mem_pkg::*;
(
    input  wire  i_if_req,
    input  wire  i_d_req,
    input  wire  i_last_owner,
    output logic o_winner
);

    // Winner selection
    always_comb begin
        o_winner = i_last_owner;
`ifdef ARB_RR_EN
        if (i_if_req && i_d_req) begin
            o_winner = (i_last_owner == c_owner_data) ? c_owner_fetch : c_owner_data;
        end else if (i_d_req) begin
            o_winner = c_owner_data;
        end else if (i_if_req) begin
            o_winner = c_owner_fetch;
        end
`else
        if (i_d_req) begin
            o_winner = c_owner_data;
        end else if (i_if_req) begin
            o_winner = c_owner_fetch;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates an instruction-fetch port and a load/store port
//                onto a single memory port with at most one transaction in
//                flight. Winner attributes are latched at arbitration and
//                held on the memory port until accepted; the response is
//                registered and routed back to the owner.
//                Optional macro ARB_RR_EN selects round-robin arbitration
//                instead of fixed data priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire          clk,
    input  wire          rst_n,
    mem_arbiter_if.slave bus,
    output logic         busy,
    output logic         owner,
    output logic         err_unexp
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_be;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_if_rvalid;
    logic                  r_d_rvalid;
    logic                  r_err;

    logic                  w_any_req;
    logic                  w_arb;
    logic                  w_resp;
    logic                  w_winner;
    logic                  w_last;

    assign w_any_req = bus.if_req | bus.d_req;
    // Arbitrate from IDLE, or back-to-back on the response cycle
    assign w_arb     = w_any_req &
                       ((r_state == IDLE) | ((r_state == RESP) & bus.mem_rvalid));
    assign w_resp    = (r_state == RESP) & bus.mem_rvalid;

`ifdef ARB_RR_EN
    logic r_last;

    // Remember who was granted last; reset value lets data win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= c_owner_fetch;
        end else if ((r_state == REQ) && bus.mem_gnt) begin
            r_last <= r_owner;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = r_owner;
`endif

    arb_pick u_arb_pick (
        .i_if_req     (bus.if_req),
        .i_d_req      (bus.d_req),
        .i_last_owner (w_last),
        .o_winner     (w_winner)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req)      w_next = REQ;
            REQ:     if (bus.mem_gnt)    w_next = RESP;
            RESP:    if (bus.mem_rvalid) w_next = w_any_req ? REQ : IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    // FSM outputs: memory request, accept pulses and busy flag
    always_comb begin
        bus.mem_req = 1'b0;
        bus.if_gnt  = 1'b0;
        bus.d_gnt   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            REQ: begin
                bus.mem_req = 1'b1;
                busy        = 1'b1;
                if (bus.mem_gnt) begin
                    if (r_owner == c_owner_data) begin
                        bus.d_gnt  = 1'b1;
                    end else begin
                        bus.if_gnt = 1'b1;
                    end
                end
            end
            RESP:    busy = 1'b1;
            default: ;
        endcase
    end

    // Latch the winner's attributes once, on the arbitration cycle only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= c_owner_fetch;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_arb) begin
            r_owner <= w_winner;
            if (w_winner == c_owner_data) begin
                r_we    <= bus.d_we;
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wdata;
                r_be    <= bus.d_be;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= bus.if_addr;
                r_wdata <= '0;
                r_be    <= '1;
            end
        end
    end

    // Register the response, route it to the owner, flag stray responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_rvalid <= w_resp & (r_owner == c_owner_fetch);
            r_d_rvalid  <= w_resp & (r_owner == c_owner_data);
            if (w_resp) begin
                r_rdata <= bus.mem_rdata;
            end
            if (bus.mem_rvalid && (r_state != RESP)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_be    = r_be;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.if_rdata  = r_rdata;
    assign bus.d_rdata   = r_rdata;
    assign owner         = r_owner;
    assign err_unexp     = r_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W SHALL default to 32 and set the width of every address bus.
REQ-002 Parameter DATA_W SHALL default to 32 and set the width of every data bus; the byte-enable width SHALL be DATA_W/8.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  / if_addr  in  ADDR_W: instruction-fetch read request and address.
REQ-006 if_gnt  out  1  / if_rvalid  out  1  / if_rdata  out  DATA_W: fetch accept pulse, response pulse and read data.
REQ-007 d_req  in  1  / d_we  in  1  / d_addr  in  ADDR_W  / d_wdata  in  DATA_W  / d_be  in  DATA_W/8: load/store request.
REQ-008 d_gnt  out  1  / d_rvalid  out  1  / d_rdata  out  DATA_W: data accept pulse, response pulse and read data.
REQ-009 mem_req, mem_we  out  1  / mem_addr  out  ADDR_W  / mem_wdata  out  DATA_W  / mem_be  out  DATA_W/8: shared memory port.
REQ-010 mem_gnt  in  1  / mem_rvalid  in  1  / mem_rdata  in  DATA_W: memory accept and response.
REQ-011 busy  out  1  transaction in flight; owner  out  1  current owner (0 = fetch, 1 = data); err_unexp  out  1  sticky protocol error.

Function
REQ-012 FSM states: IDLE, REQ, RESP; at most one outstanding memory transaction.
REQ-013 In IDLE with any requester asserting req, the FSM SHALL arbitrate, latch the winner's attributes into registers and enter REQ on the next edge, so mem_req rises one cycle after the request.
REQ-014 For fetch transactions, mem_we SHALL be 0 and mem_be all ones.
REQ-015 In REQ, mem_req and all mem_* attributes SHALL hold stable until mem_gnt=1; on that cycle the winner's gnt SHALL pulse for exactly one cycle and the FSM SHALL enter RESP.
REQ-016 In RESP, on mem_rvalid=1 the owner's rvalid SHALL pulse for one cycle, with rdata equal to mem_rdata registered from that cycle; writes also receive an rvalid acknowledge.
REQ-017 On the mem_rvalid cycle, if any request is pending the FSM SHALL arbitrate and go directly to REQ; otherwise it SHALL go to IDLE.
REQ-018 A requester SHALL hold req and its attributes until its gnt; the arbiter SHALL NOT sample attributes after the arbitration cycle.
REQ-019 Default arbitration SHALL be fixed priority: data wins over fetch.
REQ-020 mem_rvalid in IDLE or REQ SHALL be ignored for routing and SHALL set err_unexp, which is cleared only by reset.
REQ-021 busy SHALL be 1 in REQ and RESP; owner SHALL reflect the latched winner and hold its last value in IDLE.
REQ-022 Non-owner rvalid and both gnt outputs SHALL be 0 except in the cycles defined above.

Reset
REQ-023 rst_n=0 SHALL force the FSM to IDLE immediately, abandoning any in-flight transaction, with no gnt or rvalid for it after release.
REQ-024 The reset value of every output SHALL be 0, including mem_req, all gnt/rvalid, rdata, busy, owner and err_unexp; the round-robin pointer SHALL reset to favour data.

Configuration
REQ-025 With ARB_RR_EN defined, arbitration SHALL be round-robin: on contention, the requester not granted last wins.
REQ-026 Without ARB_RR_EN, arbitration SHALL be fixed data priority, and the last-grant pointer register SHALL NOT exist.

Structure
REQ-027 The state enum (IDLE/REQ/RESP) and owner encoding constants SHALL live in shared package riscv_mem_pkg.
REQ-028 The priority and round-robin decision SHALL be sub-module arb_pick (inputs: two requests and the last owner; output: winner).

Verification
REQ-029 Reset with if_req=1 only and mem_gnt tied to 1 -> mem_req=1 one cycle after release, with mem_addr=if_addr and mem_we=0; if_gnt pulses once.
REQ-030 if_req=d_req=1 together without ARB_RR_EN -> data is granted first and fetch second, with no idle cycle if fetch is pending at the first mem_rvalid.
REQ-031 With ARB_RR_EN, both requests held high for 4 transactions -> grant order D, I, D, I.
REQ-032 Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0x3, mem_gnt delayed 3 cycles -> attributes stable for all 3 cycles, then d_gnt and later d_rvalid each pulse once.
REQ-033 mem_rvalid=1 while in IDLE -> err_unexp=1 and stays 1 until rst_n=0, with no rvalid to either requester.
REQ-034 rst_n=0 during RESP -> all outputs 0 at once, and a stale mem_rvalid after release only sets err_unexp.
